// File: rtl/icmp_pkg.sv
// icmp_pkg: shared state encoding, IPv4/ICMP header constants and the
// ones'-complement helper used by the echo responder.
package icmp_pkg;
  typedef enum logic [2:0] {IDLE, RECV, DROP, CHECK, SEND} state_t;
  localparam logic [7:0] IPV4_VER_IHL = 8'h45;
  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] ICMP_ECHO_REQ = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REPLY = 8'd0;
  localparam int W_SRC = 3;
  localparam int W_DST = 4;
  localparam int W_ICMP = 5;
  localparam int MIN_WORDS = 7;
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/icmp_pkt_buffer.sv
// icmp_pkt_buffer: simple dual-port packet RAM, one write and one registered read per cycle.
module icmp_pkt_buffer #(
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/icmp_echo_responder.sv
// icmp_echo_responder: store-and-forward ICMP echo responder on 32-bit Avalon-ST;
// buffers one IPv4 packet, validates it and replays it as an echo reply.
module icmp_echo_responder
  import icmp_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int CHECK_DST = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      stream_in_data,
  input  logic [1:0]       stream_in_empty,
  input  logic             stream_in_valid,
  input  logic             stream_in_startofpacket,
  input  logic             stream_in_endofpacket,
  output logic             stream_in_ready,
  output logic [31:0]      stream_out_data,
  output logic [1:0]       stream_out_empty,
  output logic             stream_out_valid,
  output logic             stream_out_startofpacket,
  output logic             stream_out_endofpacket,
  input  logic             stream_out_ready,
  input  logic [31:0]      local_ip,
  output logic [CNT_W-1:0] stat_replies,
  output logic [CNT_W-1:0] stat_drops
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  state_t r_state, w_next;
  logic r_live;
  logic [IW-1:0] r_cnt, r_oidx, w_idx;
  logic [1:0] r_empty;
  logic [7:0] r_vihl, r_proto;
  logic [31:0] r_w3, r_w4, r_w5, w_rdata, w_word;
  logic [15:0] w_csum;
  logic [CNT_W-1:0] r_replies, r_drops;
  logic w_acc, w_ovf, w_take, w_bad, w_last, w_xfer, w_re, w_drop, w_reply;
  logic [AW-1:0] w_raddr;

  assign stream_in_ready = r_live && (r_state == IDLE || r_state == RECV || r_state == DROP);
  assign w_acc = stream_in_valid && stream_in_ready;
  assign w_idx = stream_in_startofpacket ? '0 : r_cnt;
  assign w_ovf = w_idx[AW];
  assign w_take = w_acc && ((r_state == IDLE) ? stream_in_startofpacket : (r_state == RECV && !w_ovf));
  assign w_bad = r_cnt < IW'(MIN_WORDS) || r_vihl != IPV4_VER_IHL || r_proto != PROTO_ICMP ||
                 r_w5[7:0] != ICMP_ECHO_REQ || r_w5[15:8] != 8'h00 || (CHECK_DST != 0 && r_w4 != local_ip);
  assign w_last = (r_oidx + IW'(1)) == r_cnt;
  assign w_xfer = stream_out_valid && stream_out_ready;
  // Read one word ahead so the next word is waiting as soon as the current one transfers.
  assign w_re = r_state == CHECK || w_xfer;
  assign w_raddr = (r_state == CHECK) ? '0 : AW'(r_oidx + IW'(1));
  assign w_csum = ones_add16({r_w5[23:16], r_w5[31:24]}, 16'h0800);

  icmp_pkt_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .i_we(w_take), .i_waddr(w_idx[AW-1:0]), .i_wdata(stream_in_data),
    .i_re(w_re), .i_raddr(w_raddr), .o_rdata(w_rdata)
  );

  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    w_reply = 1'b0;
    case (r_state)
      IDLE: if (w_acc && stream_in_startofpacket) w_next = stream_in_endofpacket ? CHECK : RECV;
      RECV: if (w_acc) begin
        w_drop = stream_in_startofpacket || (w_ovf && stream_in_endofpacket);
        w_next = w_ovf ? (stream_in_endofpacket ? IDLE : DROP) : (stream_in_endofpacket ? CHECK : RECV);
      end
      DROP: if (w_acc && stream_in_endofpacket) begin
        w_drop = 1'b1;
        w_next = IDLE;
      end
      CHECK: begin
        w_drop = w_bad;
        w_next = w_bad ? IDLE : SEND;
      end
      SEND: if (w_xfer && w_last) begin
        w_reply = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_live <= 1'b0;
      r_cnt <= '0;
      r_oidx <= '0;
      r_empty <= '0;
      r_vihl <= '0;
      r_proto <= '0;
      r_w3 <= '0;
      r_w4 <= '0;
      r_w5 <= '0;
      r_replies <= '0;
      r_drops <= '0;
    end else begin
      r_state <= w_next;
      r_live <= 1'b1;
      if (w_take) begin
        r_cnt <= w_idx + IW'(1);
        if (stream_in_endofpacket) r_empty <= stream_in_empty;
        if (w_idx == '0) r_vihl <= stream_in_data[7:0];
        if (w_idx == IW'(2)) r_proto <= stream_in_data[15:8];
        if (w_idx == IW'(W_SRC)) r_w3 <= stream_in_data;
        if (w_idx == IW'(W_DST)) r_w4 <= stream_in_data;
        if (w_idx == IW'(W_ICMP)) r_w5 <= stream_in_data;
      end
      r_oidx <= (r_state == CHECK) ? '0 : r_oidx + IW'(w_xfer);
      if (w_drop && r_drops != '1) r_drops <= r_drops + CNT_W'(1);
      if (w_reply && r_replies != '1) r_replies <= r_replies + CNT_W'(1);
    end
  end

  assign w_word = (r_oidx == IW'(W_SRC)) ? r_w4 :
                  (r_oidx == IW'(W_DST)) ? r_w3 :
                  (r_oidx == IW'(W_ICMP)) ? {w_csum[7:0], w_csum[15:8], r_w5[15:8], ICMP_ECHO_REPLY} : w_rdata;
  assign stream_out_valid = r_state == SEND;
  assign stream_out_data = stream_out_valid ? w_word : '0;
  assign stream_out_startofpacket = stream_out_valid && r_oidx == '0;
  assign stream_out_endofpacket = stream_out_valid && w_last;
  assign stream_out_empty = stream_out_endofpacket ? r_empty : 2'b00;
  assign stat_replies = r_replies;
  assign stat_drops = r_drops;
endmodule
